reg_file_onehot_wr: RTL

- 32-entry x 32-bit register file that consumes the one-hot write-select vector produced by the 5:32 write-address decoder.
- Provides two combinational read ports with same-cycle write bypass.
- Includes a sequential 32-cycle bulk-clear engine and a sticky error flag for malformed (non-one-hot) write selects.
- Sits between the decoder and the datapath operand muxes.

---
 rtl/reg_file_onehot_wr_pkg.sv | 34 +++
 rtl/reg_file_onehot_wr_onehot_encoder.sv | 33 +++
 rtl/reg_file_onehot_wr.sv | 122 ++++++++++++
 3 files changed

// File: rtl/reg_file_onehot_wr_pkg.sv
// Shared constants and types for the one-hot-written register file.
// The clear-FSM state and write-select classification live here.
package reg_file_onehot_wr_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned ZERO_REG = 31;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_SINGLE = 2'd1,
      SEL_MULTI  = 2'd2
   } wr_class_t;

   // Multi wins over valid so a malformed select can never look like a write.
   function automatic wr_class_t classify_sel(input logic valid, input logic multi);
      wr_class_t c;
      if (multi) begin
         c = SEL_MULTI;
      end else if (valid) begin
         c = SEL_SINGLE;
      end else begin
         c = SEL_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/reg_file_onehot_wr_onehot_encoder.sv
// Combinational one-hot to binary encoder with exactly-one and two-or-more flags.
module onehot_encoder
   import reg_file_onehot_wr_pkg::*;
(
   input  logic [NUM_REGS-1:0] vec,
   output logic [ADDR_W-1:0]   idx,
   output logic                valid,
   output logic                multi
);

   logic seen_s;

   // Scan all bits: OR the set indices together and track one/two-or-more hits.
   always_comb begin
      idx    = {ADDR_W{1'b0}};
      seen_s = 1'b0;
      multi  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (vec[i]) begin
            if (seen_s) begin
               multi = 1'b1;
            end else begin
               seen_s = 1'b1;
            end
            idx = idx | ADDR_W'(i);
         end else begin
            idx = idx;
         end
      end
      valid = seen_s & ~multi;
   end

endmodule

// File: rtl/reg_file_onehot_wr.sv
// 32x32 register file written through a one-hot select, with write-first
// bypass on two read ports, a 32-cycle bulk-clear engine and a sticky select error.
module reg_file_onehot_wr
   import reg_file_onehot_wr_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REGS-1:0] wr_sel,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic [DATA_W-1:0]   rd_data_b,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                onehot_err
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   clr_state_t        state_r;
   logic [ADDR_W-1:0] cnt_r;
   logic              clr_busy_r;
   logic              onehot_err_r;

   logic [ADDR_W-1:0] wr_idx_s;
   logic              sel_valid_s;
   logic              sel_multi_s;
   wr_class_t         wr_class_s;
   logic              wr_ok_s;

   onehot_encoder u_enc (
      .vec   (wr_sel),
      .idx   (wr_idx_s),
      .valid (sel_valid_s),
      .multi (sel_multi_s)
   );

   // Accept a write only for a clean single select, engine idle, not the zero register.
   always_comb begin
      wr_class_s = classify_sel(sel_valid_s, sel_multi_s);
      case (wr_class_s)
         SEL_SINGLE: wr_ok_s = (state_r == ST_IDLE) && (wr_idx_s != ZERO_IDX);
         SEL_NONE:   wr_ok_s = 1'b0;
         SEL_MULTI:  wr_ok_s = 1'b0;
         default:    wr_ok_s = 1'b0;
      endcase
   end

   // Read port A: zero register first, then write-first bypass, then storage.
   always_comb begin
      if (rd_addr_a == ZERO_IDX) begin
         rd_data_a = {DATA_W{1'b0}};
      end else if (wr_ok_s && (rd_addr_a == wr_idx_s)) begin
         rd_data_a = wr_data;
      end else begin
         rd_data_a = regs_r[rd_addr_a];
      end
   end

   // Read port B: identical to port A, fully independent.
   always_comb begin
      if (rd_addr_b == ZERO_IDX) begin
         rd_data_b = {DATA_W{1'b0}};
      end else if (wr_ok_s && (rd_addr_b == wr_idx_s)) begin
         rd_data_b = wr_data;
      end else begin
         rd_data_b = regs_r[rd_addr_b];
      end
   end

   // Storage, clear engine and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         state_r      <= ST_IDLE;
         cnt_r        <= {ADDR_W{1'b0}};
         clr_busy_r   <= 1'b0;
         onehot_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (wr_ok_s) begin
                  regs_r[wr_idx_s] <= wr_data;
               end
               // A write in the request cycle still commits; reg 0 is wiped next cycle.
               if (clr_req) begin
                  state_r    <= ST_CLEAR;
                  cnt_r      <= {ADDR_W{1'b0}};
                  clr_busy_r <= 1'b1;
               end
            end
            ST_CLEAR: begin
               regs_r[cnt_r] <= {DATA_W{1'b0}};
               if (cnt_r == LAST_IDX) begin
                  state_r    <= ST_IDLE;
                  cnt_r      <= {ADDR_W{1'b0}};
                  clr_busy_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + ADDR_W'(1);
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= {ADDR_W{1'b0}};
               clr_busy_r <= 1'b0;
            end
         endcase
         if (wr_class_s == SEL_MULTI) begin
            onehot_err_r <= 1'b1;
         end
      end
   end

   assign clr_busy   = clr_busy_r;
   assign onehot_err = onehot_err_r;

endmodule
